fib_bcd_converter: RTL and testbench

- Downstream stage of the Fibonacci generator: takes its 32-bit binary result and converts it to packed BCD for the seven-segment display driver.
- Implements a sequential shift-and-add-3 (double-dabble) conversion, one bit per clock.
- Uses a start/busy/done handshake and holds the BCD result until the next conversion.

---
 rtl/fib_bcd_converter_if.sv | 19 +
 rtl/fib_bcd_converter.sv | 127 ++++++++++++
 tb/tb_fib_bcd_converter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_bcd_converter_if.sv
// Handshake bundle between the Fibonacci generator and the BCD converter.
//   start : request a conversion (master -> slave)
//   bin   : binary value to convert (master -> slave)
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse, bcd valid (slave -> master)
//   bcd   : packed BCD result, digit 0 in [3:0] (slave -> master)
interface fib_bcd_converter_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit/clock).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fib_bcd_converter_if.slave (start, bin, busy, done, bcd)
// Optional build macro BCD_BLANK_EN: leading-zero digits above the most
// significant nonzero digit load as 4'hF (blank); digit 0 is never blanked.

// Per-digit correction: add 3 when the digit is 5 or more, so that the
// following left shift carries correctly into the next decade.
module fib_bcd_digit (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module fib_bcd_converter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int CNT_W  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    fib_bcd_converter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scratch_nxt;
    logic [4*DIGITS-1:0]   load_val;
    logic [CNT_W-1:0]      cnt;
    logic                  last;
    logic                  busy_nxt;
    logic                  done_nxt;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            fib_bcd_digit u_dig (
                .d (scratch[4*g +: 4]),
                .q (adj[4*g +: 4])
            );
        end
    endgenerate

    // Corrected scratch shifted left with the next binary MSB entering bit 0.
    assign scratch_nxt = {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    // cnt is pre-increment: this edge performs the final bit.
    assign last        = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        load_val = scratch_nxt;
`ifdef BCD_BLANK_EN
        begin : blank
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (scratch_nxt[4*i +: 4] == 4'h0))
                    load_val[4*i +: 4] = 4'hF;
                else
                    lead = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                    busy_nxt  = 1'b1;
                end
            end
            SHIFT: begin
                busy_nxt = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_nxt;
            bus.busy <= busy_nxt;
            bus.done <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bus.bcd <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                bin_sr  <= bus.bin;
                scratch <= '0;
                cnt     <= '0;
            end else if (state == SHIFT) begin
                scratch <= scratch_nxt;
                bin_sr  <= bin_sr << 1;
                cnt     <= cnt + CNT_W'(1);
                if (last)
                    bus.bcd <= load_val;
            end
        end
    end
endmodule

// File: tb/tb_fib_bcd_converter.sv
// Self-checking bench for fib_bcd_converter: table of conversions plus
// hand-written sequences (ignored start, mid-conversion reset, held start).
module tb_fib_bcd_converter;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic clk;
    logic reset;

    fib_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    fib_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bin;
        logic [39:0] exp;   // plain BCD, leading zeros as 0
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [39:0] exp_q[$];

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] blank(input logic [39:0] b);
        logic [39:0] r;
        r = b;
`ifdef BCD_BLANK_EN
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (r[4*i +: 4] != 4'h0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0] r;
        longint unsigned x;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Drive start for one cycle; returns at the negedge after the accept edge.
    task automatic start_conv(input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = b;
        @(posedge clk);
        exp_q.push_back(blank(to_bcd(b)));
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = $urandom;   // must not disturb the conversion
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    // Entered at the negedge after the accept edge.
    task automatic wait_done(input string name);
        int          lat;
        bit          seen;
        bit          busy_ok;
        logic [39:0] exp, held;
        lat = 0; seen = 0; busy_ok = 1;
        for (int i = 1; i <= WIDTH + 8; i++) begin
            @(negedge clk);
            if (bus.done) begin lat = i; seen = 1; break; end
            if (!bus.busy) busy_ok = 0;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        check({name, "_latency"}, 64'(lat), 64'(WIDTH));
        check({name, "_busy_held"}, 64'(busy_ok), 64'd1);
        check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hx;
        check({name, "_bcd"}, 64'(bus.bcd), 64'(exp));
        held = bus.bcd;
        @(negedge clk);
        check({name, "_done_single"}, 64'(bus.done), 64'd0);
        check({name, "_bcd_hold"}, 64'(bus.bcd), 64'(held));
    endtask

    vec_t vecs[11];

    initial begin
        int          dc;
        logic [31:0] r;

        vecs[0]  = '{32'd832040,     40'h0000832040};
        vecs[1]  = '{32'hFFFFFFFF,   40'h4294967295};
        vecs[2]  = '{32'd0,          40'h0000000000};
        vecs[3]  = '{32'd55,         40'h0000000055};
        vecs[4]  = '{32'd1,          40'h0000000001};
        vecs[5]  = '{32'd9,          40'h0000000009};
        vecs[6]  = '{32'd10,         40'h0000000010};
        vecs[7]  = '{32'd99,         40'h0000000099};
        vecs[8]  = '{32'd100,        40'h0000000100};
        vecs[9]  = '{32'd1000000000, 40'h1000000000};
        vecs[10] = '{32'd2971215073, 40'h2971215073};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_bcd",  64'(bus.bcd),  64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table: expected value is the constant, with optional blanking applied.
        for (int i = 0; i < 11; i++) begin
            check($sformatf("model_vec%0d", i), 64'(to_bcd(vecs[i].bin)), 64'(vecs[i].exp));
            start_conv(vecs[i].bin);
            // replace the model entry with the table's own constant
            void'(exp_q.pop_back());
            exp_q.push_back(blank(vecs[i].exp));
            wait_done($sformatf("vec%0d", i));
        end
`ifdef BCD_BLANK_EN
        check("blank_zero_const", 64'(blank(40'h0)),  64'(40'hFFFFFFFFF0));
        check("blank_55_const",   64'(blank(40'h55)), 64'(40'hFFFFFFFF55));
`endif

        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            start_conv(r);
            wait_done($sformatf("rand%0d", i));
        end

        // Start during busy is ignored: 55, then 89 with 144 pulsed at cycle 10.
        start_conv(32'd55);
        wait_done("seq55");
        dc = done_cnt;
        start_conv(32'd89);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 32'd144;
        @(negedge clk);
        bus.start = 1'b0;
        // 10 of the 32 cycles already consumed
        begin : rest89
            int  lat;
            bit  seen;
            lat = 0; seen = 0;
            for (int i = 11; i <= WIDTH + 8; i++) begin
                @(negedge clk);
                if (bus.done) begin lat = i; seen = 1; break; end
            end
            check("ign_done_seen", 64'(seen), 64'd1);
            check("ign_latency", 64'(lat), 64'(WIDTH));
            check("ign_bcd", 64'(bus.bcd), 64'(blank(40'h0000000089)));
            void'(exp_q.pop_front());
        end
        repeat (WIDTH + 4) @(negedge clk);
        check("ign_one_done", 64'(done_cnt - dc), 64'd1);

        // Reset mid-conversion.
        start_conv(32'd1000);
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_bcd",  64'(bus.bcd),  64'd0);
        void'(exp_q.pop_front());
        dc = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (WIDTH + 6) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - dc), 64'd0);
        check("midrst_bcd_after", 64'(bus.bcd), 64'd0);

        // Start held high: second accept exactly WIDTH+2 edges after the first.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 32'd21;
        @(posedge clk);
        exp_q.push_back(blank(40'h21));
        @(negedge clk);
        check("held_busy", 64'(bus.busy), 64'd1);
        wait_done("held1");
        // now at negedge after edge k+WIDTH+1 (DONE -> IDLE)
        bus.bin = 32'd34;
        check("held_idle_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        exp_q.push_back(blank(40'h34));
        @(negedge clk);
        bus.start = 1'b0;
        check("held_reaccept", 64'(bus.busy), 64'd1);
        wait_done("held2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
